mul_share_arbiter: RTL and testbench
====================================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one multiplier (power of two, 2..8).
REQ-002 SHALL have parameter A_W, default 13, operand-A width (signed two's complement).
REQ-003 SHALL have parameter B_W, default 12, operand-B width (signed two's complement).
REQ-004 SHALL have parameter R_W, default 12, multiplier result width after fixed-point match.
REQ-005 SHALL have parameter MUL_LAT, default 1, cycles from o_mul_vld to matching i_mul_res (>=1).
REQ-006 i_clk  in  1  sole clock, all flops rising-edge.
REQ-007 i_rst  in  1  asynchronous, active-high reset.
REQ-008 i_en  in  1  grant enable; 0 blocks new grants.
REQ-009 i_req_valid  in  N_REQ  per-requester request valid.
REQ-010 o_req_ready  out  N_REQ  per-requester accept, one-hot or zero.
REQ-011 i_req_a  in  N_REQ*A_W  packed operand A, requester k at [k*A_W +: A_W].
REQ-012 i_req_b  in  N_REQ*B_W  packed operand B, requester k at [k*B_W +: B_W].
REQ-013 o_mul_a / o_mul_b  out  A_W / B_W  operands to shared multiplier.
REQ-014 o_mul_vld  out  1  operands on o_mul_a/b are a new issue.
REQ-015 i_mul_res  in  R_W  multiplier result, MUL_LAT cycles after issue.
REQ-016 o_res_valid / o_res_id / o_res_data  out  1 / log2(N_REQ) / R_W  returned result, owner id, value.
REQ-017 o_busy  out  1  any issue in flight; o_issue_cnt  out  16  total issues, wrapping.

Function
REQ-018 Accept on requester k SHALL occur in a cycle where i_req_valid[k] & o_req_ready[k].
REQ-019 o_req_ready SHALL be combinational from i_req_valid, i_en and pointer; at most one bit set; all zero when i_en=0.
REQ-020 Grant SHALL be round-robin: first valid requester searching pointer, pointer+1, ... mod N_REQ.
REQ-021 After a grant to g, pointer SHALL become (g+1) mod N_REQ; with no grant, pointer unchanged.
REQ-022 Accept at cycle t SHALL register selected operands: o_mul_a/o_mul_b/o_mul_vld=1 at t+1.
REQ-023 With no accept, o_mul_vld SHALL be 0 next cycle and o_mul_a/o_mul_b SHALL hold prior values.
REQ-024 A tag pipeline of depth MUL_LAT SHALL carry {valid, id} alongside each issue.
REQ-025 i_mul_res SHALL be sampled at t+1+MUL_LAT; o_res_valid=1, o_res_id=g, o_res_data=i_mul_res at t+2+MUL_LAT.
REQ-026 Accept-to-result latency SHALL be exactly MUL_LAT+2 cycles; throughput one issue per cycle, no bubbles.
REQ-027 Results SHALL return in issue order; no result backpressure; o_res_data holds when o_res_valid=0.
REQ-028 o_busy SHALL be 1 while any tag stage or output stage holds valid, or o_mul_vld=1.
REQ-029 o_issue_cnt SHALL increment by 1 per accept, wrapping 0xFFFF->0x0000.
REQ-030 i_en falling SHALL not cancel in-flight issues; they complete per REQ-025.
REQ-031 Requester dropping valid before ready SHALL lose nothing; arbiter keeps no request memory.
REQ-032 Operands SHALL pass unmodified (no sign handling); width/sign arithmetic belongs to the multiplier.

Reset
REQ-033 On i_rst=1, immediately and independent of i_clk: pointer=0, tag pipeline cleared, o_mul_vld=0, o_mul_a=0, o_mul_b=0, o_res_valid=0, o_res_id=0, o_res_data=0, o_busy=0, o_issue_cnt=0.
REQ-034 Reset mid-operation SHALL discard all in-flight issues; no o_res_valid for them after release.
REQ-035 o_req_ready SHALL be 0 while i_rst=1.

Verification
REQ-036 Single: requester 2 valid, a=3, b=5, MUL_LAT=1, bench multiplier returns 15 -> ready[2] at t, o_mul_vld at t+1, o_res_valid/id=2/data=15 at t+3.
REQ-037 All four valid continuously from pointer 0 -> grants 0,1,2,3,0 on consecutive cycles, o_issue_cnt=5, results in same id order.
REQ-038 Fairness: after grant to 1, requesters 0 and 1 valid -> grant 0 not 1 (search from 2 wraps to 0).
REQ-039 Reset mid-flight: accept at t, i_rst pulsed at t+1 -> outputs 0 immediately, no o_res_valid at t+3.
REQ-040 i_en=0 for 3 cycles with all valid -> o_req_ready=0, pointer unchanged, earlier issues still return, o_busy falls after drain.
REQ-041 Counter wrap: 65537 accepts -> o_issue_cnt=0x0001.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one external multiplier between N_REQ requesters.
// Issues one operand pair per cycle and returns tagged results in issue order.
module mul_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned A_W     = 13,
  parameter int unsigned B_W     = 12,
  parameter int unsigned R_W     = 12,
  parameter int unsigned MUL_LAT = 1,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*A_W-1:0]   i_req_a,
  input  logic [N_REQ*B_W-1:0]   i_req_b,
  output logic [A_W-1:0]         o_mul_a,
  output logic [B_W-1:0]         o_mul_b,
  output logic                   o_mul_vld,
  input  logic [R_W-1:0]         i_mul_res,
  output logic                   o_res_valid,
  output logic [ID_W-1:0]        o_res_id,
  output logic [R_W-1:0]         o_res_data,
  output logic                   o_busy,
  output logic [15:0]            o_issue_cnt
);

  logic [ID_W-1:0]               ptr_q;
  logic                          grant_vld;
  logic [ID_W-1:0]               grant_id;
  logic [ID_W-1:0]               idx;
  logic                          accept;
  logic [A_W-1:0]                sel_a;
  logic [B_W-1:0]                sel_b;

  logic [A_W-1:0]                mul_a_q;
  logic [B_W-1:0]                mul_b_q;
  logic                          mul_vld_q;
  logic [ID_W-1:0]               issue_id_q;

  logic [MUL_LAT-1:0]            tag_vld_q;
  logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q;

  logic                          res_valid_q;
  logic [ID_W-1:0]               res_id_q;
  logic [R_W-1:0]                res_data_q;
  logic [15:0]                   issue_cnt_q;

  // First valid requester at or after the pointer; N_REQ is a power of two so
  // ID_W-bit addition wraps modulo N_REQ for free.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr_q;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!grant_vld && i_req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    sel_a = i_req_a[32'(grant_id) * A_W +: A_W];
    sel_b = i_req_b[32'(grant_id) * B_W +: B_W];
  end

  assign accept      = grant_vld & i_en & ~i_rst;
  assign o_req_ready = accept ? (N_REQ'(1) << grant_id) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_vld_q   <= 1'b0;
      issue_id_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      mul_vld_q <= accept;
      if (accept) begin
        ptr_q       <= grant_id + ID_W'(1);
        mul_a_q     <= sel_a;
        mul_b_q     <= sel_b;
        issue_id_q  <= grant_id;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
    end
  end

  // Tag stage MUL_LAT-1 lines up with i_mul_res for the same issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= mul_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tag_vld_q[MUL_LAT-1];
      if (tag_vld_q[MUL_LAT-1]) begin
        res_id_q   <= tag_id_q[MUL_LAT-1];
        res_data_q <= i_mul_res;
      end
    end
  end

  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  assign o_mul_vld   = mul_vld_q;
  assign o_res_valid = res_valid_q;
  assign o_res_id    = res_id_q;
  assign o_res_data  = res_data_q;
  assign o_issue_cnt = issue_cnt_q;
  assign o_busy      = (|tag_vld_q) | res_valid_q | mul_vld_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a negedge monitor models the arbiter and
// checks every cycle, while scenario tasks drive traffic and add targeted checks.
module tb_mul_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int A_W     = 13;
  localparam int B_W     = 12;
  localparam int R_W     = 12;
  localparam int MUL_LAT = 1;
  localparam int ID_W    = $clog2(N_REQ);

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_en  = 1'b0;
  logic [N_REQ-1:0]     i_req_valid = '0;
  logic [N_REQ-1:0]     o_req_ready;
  logic [N_REQ*A_W-1:0] i_req_a = '0;
  logic [N_REQ*B_W-1:0] i_req_b = '0;
  logic [A_W-1:0]       o_mul_a;
  logic [B_W-1:0]       o_mul_b;
  logic                 o_mul_vld;
  logic [R_W-1:0]       i_mul_res;
  logic                 o_res_valid;
  logic [ID_W-1:0]      o_res_id;
  logic [R_W-1:0]       o_res_data;
  logic                 o_busy;
  logic [15:0]          o_issue_cnt;

  mul_share_arbiter #(
    .N_REQ  (N_REQ),
    .A_W    (A_W),
    .B_W    (B_W),
    .R_W    (R_W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_a    (i_req_a),
    .i_req_b    (i_req_b),
    .o_mul_a    (o_mul_a),
    .o_mul_b    (o_mul_b),
    .o_mul_vld  (o_mul_vld),
    .i_mul_res  (i_mul_res),
    .o_res_valid(o_res_valid),
    .o_res_id   (o_res_id),
    .o_res_data (o_res_data),
    .o_busy     (o_busy),
    .o_issue_cnt(o_issue_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_on  = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [R_W-1:0] prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic signed [A_W+B_W-1:0] p;
    p = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
    return p[R_W-1:0];
  endfunction

  // Bench-side multiplier with MUL_LAT register stages.
  logic [R_W-1:0] mul_pipe [MUL_LAT];
  always @(posedge i_clk) begin
    mul_pipe[0] <= prod(o_mul_a, o_mul_b);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign i_mul_res = mul_pipe[MUL_LAT-1];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [R_W-1:0]  data;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  int              m_ptr = 0;
  logic [15:0]     m_cnt = '0;
  logic            m_vld = 1'b0;
  logic [A_W-1:0]  m_a = '0;
  logic [B_W-1:0]  m_b = '0;
  logic [R_W-1:0]  m_last = '0;

  task automatic clear_model();
    sb.delete();
    m_ptr  = 0;
    m_cnt  = '0;
    m_vld  = 1'b0;
    m_a    = '0;
    m_b    = '0;
    m_last = '0;
  endtask

  // Per-cycle reference model and scoreboard.
  always @(negedge i_clk) begin
    logic [N_REQ-1:0] exp_rdy;
    bit               found;
    int               g;
    int               idx;
    exp_t             e;
    if (mon_on) begin
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      if (i_en && !i_rst) begin
        for (int i = 0; i < N_REQ; i++) begin
          idx = (m_ptr + i) % N_REQ;
          if (!found && i_req_valid[idx]) begin
            found = 1'b1;
            g     = idx;
          end
        end
      end
      if (found) exp_rdy[g] = 1'b1;
      n_tests++;
      if (o_req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, exp_rdy);
      end
      if (!i_rst) begin
        n_tests++;
        if (o_mul_vld !== m_vld || o_mul_a !== m_a || o_mul_b !== m_b) begin
          n_fail++;
          $display("FAIL issue cyc=%0d got vld=%b a=%h b=%h exp vld=%b a=%h b=%h",
                   cyc, o_mul_vld, o_mul_a, o_mul_b, m_vld, m_a, m_b);
        end
        n_tests++;
        if (o_issue_cnt !== m_cnt) begin
          n_fail++;
          $display("FAIL issue_cnt cyc=%0d got=%h exp=%h", cyc, o_issue_cnt, m_cnt);
        end
        n_tests++;
        if (o_busy !== (sb.size() != 0)) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, sb.size() != 0);
        end
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_result cyc=%0d got none exp id=%0d at cyc=%0d", cyc, e.id, e.cyc);
        end
        if (o_res_valid === 1'b1) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result cyc=%0d got id=%0d data=%h exp none",
                     cyc, o_res_id, o_res_data);
          end else begin
            e = sb.pop_front();
            if (o_res_id !== e.id || o_res_data !== e.data || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL result cyc=%0d got id=%0d data=%h exp id=%0d data=%h cyc=%0d",
                       cyc, o_res_id, o_res_data, e.id, e.data, e.cyc);
            end
            m_last = e.data;
          end
        end else begin
          n_tests++;
          if (o_res_valid !== 1'b0 || o_res_data !== m_last) begin
            n_fail++;
            $display("FAIL res_hold cyc=%0d got vld=%b data=%h exp vld=0 data=%h",
                     cyc, o_res_valid, o_res_data, m_last);
          end
        end
        m_vld = found;
        if (found) begin
          m_a    = i_req_a[g*A_W +: A_W];
          m_b    = i_req_b[g*B_W +: B_W];
          m_ptr  = (g + 1) % N_REQ;
          m_cnt  = m_cnt + 16'd1;
          e.id   = ID_W'(g);
          e.data = prod(m_a, m_b);
          e.cyc  = cyc + MUL_LAT + 2;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic set_inputs(input logic [N_REQ-1:0] v, input logic en);
    i_req_valid = v;
    i_en        = en;
    for (int k = 0; k < N_REQ; k++) begin
      i_req_a[k*A_W +: A_W] = A_W'($urandom);
      i_req_b[k*B_W +: B_W] = B_W'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    clear_model();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    @(posedge i_clk); #1;
    set_inputs('0, 1'b1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge i_clk); #1;
    set_inputs('1, 1'b1);
    i_rst = 1'b1;
    clear_model();
    #1;
    n_tests++;
    if (o_req_ready !== '0 || o_mul_vld !== 1'b0 || o_mul_a !== '0 || o_mul_b !== '0 ||
        o_res_valid !== 1'b0 || o_res_id !== '0 || o_res_data !== '0 || o_busy !== 1'b0 ||
        o_issue_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b a=%h b=%h rv=%b id=%0d d=%h busy=%b cnt=%h exp all 0",
               o_req_ready, o_mul_vld, o_mul_a, o_mul_b, o_res_valid, o_res_id, o_res_data,
               o_busy, o_issue_cnt);
    end
    mon_on = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    set_inputs('0, 1'b1);
  endtask

  task automatic test_single();
    do_reset();
    set_inputs(4'b0100, 1'b1);
    i_req_a[2*A_W +: A_W] = A_W'(3);
    i_req_b[2*B_W +: B_W] = B_W'(5);
    @(negedge i_clk);
    n_tests++;
    if (o_req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=0100", o_req_ready);
    end
    @(posedge i_clk); #1;
    set_inputs('0, 1'b1);
    @(negedge i_clk);
    n_tests++;
    if (o_mul_vld !== 1'b1 || o_mul_a !== A_W'(3) || o_mul_b !== B_W'(5)) begin
      n_fail++;
      $display("FAIL single_issue got vld=%b a=%0d b=%0d exp vld=1 a=3 b=5", o_mul_vld, o_mul_a, o_mul_b);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    n_tests++;
    if (o_res_valid !== 1'b1 || o_res_id !== ID_W'(2) || o_res_data !== R_W'(15)) begin
      n_fail++;
      $display("FAIL single_result got vld=%b id=%0d data=%0d exp vld=1 id=2 data=15",
               o_res_valid, o_res_id, o_res_data);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] exp_r;
    do_reset();
    set_inputs('1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      exp_r = N_REQ'(1) << (i % N_REQ);
      n_tests++;
      if (o_req_ready !== exp_r) begin
        n_fail++;
        $display("FAIL b2b_grant%0d got=%b exp=%b", i, o_req_ready, exp_r);
      end
    end
    idle(4);
    @(negedge i_clk);
    n_tests++;
    if (o_issue_cnt !== 16'd5 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count got cnt=%0d busy=%b exp cnt=5 busy=0", o_issue_cnt, o_busy);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    set_inputs(4'b0010, 1'b1);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    set_inputs(4'b0011, 1'b1);
    @(negedge i_clk);
    n_tests++;
    if (o_req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL fairness got=%b exp=0001", o_req_ready);
    end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_inputs(4'b0001, 1'b1);
    @(posedge i_clk); #1;
    set_inputs('0, 1'b1);
    #1;
    i_rst = 1'b1;
    clear_model();
    #1;
    n_tests++;
    if (o_mul_vld !== 1'b0 || o_busy !== 1'b0 || o_issue_cnt !== '0 || o_mul_a !== '0 ||
        o_res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset got vld=%b busy=%b cnt=%h a=%h rv=%b exp all 0",
               o_mul_vld, o_busy, o_issue_cnt, o_mul_a, o_res_valid);
    end
    #1;
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_tests++;
      if (o_res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_discard%0d got res_valid=%b exp 0", i, o_res_valid);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    set_inputs('1, 1'b1);
    repeat (2) @(negedge i_clk);
    @(posedge i_clk); #1;
    set_inputs('1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_tests++;
      if (o_req_ready !== '0 || (i == 0 && o_busy !== 1'b1)) begin
        n_fail++;
        $display("FAIL en_off%0d got rdy=%b busy=%b exp rdy=0000", i, o_req_ready, o_busy);
      end
    end
    @(posedge i_clk); #1;
    set_inputs('1, 1'b1);
    @(negedge i_clk);
    n_tests++;
    if (o_req_ready !== 4'b0100 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_resume got rdy=%b busy=%b exp rdy=0100 busy=0", o_req_ready, o_busy);
    end
    idle(4);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_inputs(N_REQ'($urandom), ($urandom_range(0, 3) != 0));
      @(posedge i_clk); #1;
    end
    idle(6);
  endtask

  task automatic test_wrap();
    do_reset();
    set_inputs('1, 1'b1);
    repeat (65537) @(posedge i_clk);
    #1;
    set_inputs('0, 1'b1);
    @(negedge i_clk);
    n_tests++;
    if (o_issue_cnt !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap got cnt=%h exp=0001", o_issue_cnt);
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_reset_midflight();
    test_enable();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
